// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet constants, framer state type and byte-wise CRC-32 step.
package eth_pkg;
    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;

    typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ABORT, DRAIN, IPG} state_t;

    // Reflected CRC-32, data bits consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? ETH_CRC_POLY : 32'h0);
        return r;
    endfunction
endpackage

// File: rtl/eth_crc32_8.sv
// eth_crc32_8: byte-wide running CRC-32 register with synchronous reseed.
module eth_crc32_8 import eth_pkg::*; (
    input  logic        tx_clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) crc <= '1;
        else if (init) crc <= '1;
        else if (en) crc <= crc32_byte(crc, data);
    end
endmodule

// File: rtl/eth_mac_tx_framer.sv
// eth_mac_tx_framer: byte-stream to Ethernet frame (preamble, SFD, payload, pad, FCS) with IPG and abort handling.
module eth_mac_tx_framer import eth_pkg::*; #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IPG_BYTES      = 12,
    parameter int MIN_FRAME      = 60,
    parameter int FCS_EN         = 1
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    input  logic       s_error,
    output logic       tx_en,
    output logic       tx_err,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       stat_frame,
    output logic       stat_abort
);
    localparam int CW = (MIN_FRAME > 0) ? $clog2(MIN_FRAME + 1) : 1;
    localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME);
    localparam state_t AFTER = (FCS_EN != 0) ? FCS : IPG;

    state_t        state;
    logic [3:0]    sub;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    ipg;
    logic          skip;
    logic          pre_done;
    logic          crc_en;
    logic [31:0]   crc;
    logic [31:0]   fcs;

    assign s_ready  = (state == SFD) || (state == DATA) || (state == DRAIN);
    assign busy     = state != IDLE;
    assign cnt_inc  = (cnt == MIN_C) ? cnt : cnt + 1'b1;
    assign pre_done = sub == 4'(PREAMBLE_BYTES);
    assign crc_en   = (s_valid && !s_error && (state == SFD || state == DATA)) || state == PAD;
    assign fcs      = ~crc;

    eth_crc32_8 u_crc (
        .tx_clk(tx_clk),
        .rst_n (rst_n),
        .init  (state == PREAMBLE && pre_done),
        .en    (crc_en),
        .data  (state == PAD ? 8'h00 : s_data),
        .crc   (crc)
    );

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_en      <= 1'b0;
            tx_err     <= 1'b0;
            tx_data    <= 8'h00;
            stat_frame <= 1'b0;
            stat_abort <= 1'b0;
            sub        <= 4'd0;
            cnt        <= '0;
            ipg        <= 8'd0;
            skip       <= 1'b0;
        end else begin
            stat_frame <= 1'b0;
            stat_abort <= 1'b0;
            tx_err     <= 1'b0;
            ipg        <= (ipg != 8'd0) ? ipg - 8'd1 : 8'd0;
            case (state)
                IDLE: begin
                    tx_en   <= s_valid;
                    tx_data <= s_valid ? ETH_PREAMBLE : 8'h00;
                    sub     <= 4'd1;
                    state   <= s_valid ? PREAMBLE : IDLE;
                end
                PREAMBLE: begin
                    tx_data <= pre_done ? ETH_SFD : ETH_PREAMBLE;
                    sub     <= sub + 4'd1;
                    cnt     <= '0;
                    state   <= pre_done ? SFD : PREAMBLE;
                end
                SFD, DATA: begin
                    if (!s_valid || s_error) begin
                        state      <= ABORT;
                        tx_err     <= 1'b1;
                        tx_data    <= 8'h00;
                        stat_abort <= 1'b1;
                        skip       <= s_valid & s_last;
                    end else begin
                        tx_data <= s_data;
                        cnt     <= cnt_inc;
                        sub     <= 4'd0;
                        if (!s_last) state <= DATA;
                        else if (cnt_inc < MIN_C) state <= PAD;
                        else begin
                            state      <= AFTER;
                            stat_frame <= FCS_EN == 0;
                        end
                    end
                end
                PAD: begin
                    tx_data <= 8'h00;
                    cnt     <= cnt_inc;
                    if (cnt_inc == MIN_C) begin
                        state      <= AFTER;
                        stat_frame <= FCS_EN == 0;
                    end
                end
                FCS: begin
                    tx_data <= fcs[{sub[1:0], 3'b000} +: 8];
                    sub     <= sub + 4'd1;
                    if (sub == 4'd3) begin
                        state      <= IPG;
                        stat_frame <= 1'b1;
                    end
                end
                ABORT: begin
                    tx_en   <= 1'b0;
                    tx_data <= 8'h00;
                    ipg     <= 8'(IPG_BYTES);
                    state   <= skip ? IPG : DRAIN;
                end
                DRAIN: state <= (s_valid && s_last) ? IPG : DRAIN;
                IPG: begin
                    tx_en   <= 1'b0;
                    tx_data <= 8'h00;
                    sub     <= 4'd1;
                    // Gap counts from the first idle cycle; tx_en still high here means the frame's last byte is on the wire.
                    if (tx_en) ipg <= 8'(IPG_BYTES);
                    else if (ipg <= 8'd1) begin
                        state   <= s_valid ? PREAMBLE : IDLE;
                        tx_en   <= s_valid;
                        tx_data <= s_valid ? ETH_PREAMBLE : 8'h00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// tb_eth_mac_tx_framer: directed/random frames checked against a frame-level reference model.
module tb_eth_mac_tx_framer;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_error = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, tx_en, tx_err, busy, stat_frame, stat_abort;
    logic [7:0] tx_data;

    logic       rst_n6 = 1'b0, v6 = 1'b0, l6 = 1'b0, e6 = 1'b0;
    logic [7:0] d6 = 8'h00;
    logic       ready6, en6, err6, busy6, sf6, sa6;
    logic [7:0] data6;

    eth_mac_tx_framer dut (
        .tx_clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_error(s_error), .tx_en(tx_en), .tx_err(tx_err), .tx_data(tx_data),
        .busy(busy), .stat_frame(stat_frame), .stat_abort(stat_abort)
    );

    eth_mac_tx_framer #(.PREAMBLE_BYTES(3), .IPG_BYTES(12), .MIN_FRAME(0), .FCS_EN(0)) dut6 (
        .tx_clk(clk), .rst_n(rst_n6), .s_valid(v6), .s_ready(ready6), .s_data(d6),
        .s_last(l6), .s_error(e6), .tx_en(en6), .tx_err(err6), .tx_data(data6),
        .busy(busy6), .stat_frame(sf6), .stat_abort(sa6)
    );

    int errors = 0, checks = 0;
    int frames = 0, n_sf = 0, n_sa = 0, rx_err = 0, cur_err = 0, idle_run = 1000, last_gap = 0;
    bq_t cur, rx;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        if (tx_en) begin
            if (!prev_en) begin
                last_gap = idle_run;
                cur.delete();
                cur_err = 0;
            end
            cur.push_back(tx_data);
            if (tx_err) cur_err++;
            idle_run = 0;
        end else begin
            if (prev_en) begin
                rx = cur;
                rx_err = cur_err;
                frames++;
            end
            idle_run++;
        end
        if (stat_frame) n_sf++;
        if (stat_abort) n_sa++;
        prev_en = tx_en;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_reg(input bq_t q, input int from);
        logic [31:0] c;
        c = '1;
        for (int k = from; k < q.size(); k++)
            for (int b = 0; b < 8; b++) c = (c[0] ^ q[k][b]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return c;
    endfunction

    function automatic bq_t build_exp(input bq_t pay);
        bq_t q, body;
        logic [31:0] f;
        body = pay;
        while (body.size() < 60) body.push_back(8'h00);
        f = ~crc_reg(body, 0);
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        foreach (body[i]) q.push_back(body[i]);
        for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
        return q;
    endfunction

    function automatic bq_t build_abort(input bq_t pay, input int kept);
        bq_t q;
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < kept; i++) q.push_back(pay[i]);
        q.push_back(8'h00);
        return q;
    endfunction

    function automatic int diffs(input bq_t a, input bq_t b);
        int n;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    function automatic bq_t rand_pay(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic send(input bq_t p, input int err_idx, input int gap_idx);
        int i, g;
        logic rdy, did;
        i = 0; g = 0; did = 1'b0;
        while (i < p.size() && g < 2000) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = p[i]; s_last = (i == p.size() - 1); s_error = (i == err_idx);
            rdy = s_ready;
            if (rdy && i == gap_idx && !did) begin
                s_valid = 1'b0;
                did = 1'b1;
            end
            @(posedge clk);
            if (s_valid && rdy) i++;
            g++;
        end
        chk("send_done", i, p.size());
    endtask

    task automatic quiet();
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_timeout", frames >= target, 1);
    endtask

    bq_t pa, pb, ex;
    int f0, sf0, sa0;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst_n6 = 1'b1;
        @(negedge clk);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_err", tx_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);

        // 64-byte frame, FCS residue seen by a receiver
        pa = rand_pay(64); f0 = frames; sf0 = n_sf;
        send(pa, -1, -1); quiet(); wait_frames(f0 + 1);
        ex = build_exp(pa);
        chk("t1_len", rx.size(), 76);
        chk("t1_bytes", diffs(rx, ex), 0);
        chk("t1_residue", crc_reg(rx, 8), 32'hDEBB20E3);
        chk("t1_stat_frame", n_sf - sf0, 1);
        chk("t1_err", rx_err, 0);

        // short frame padded to 60
        pa = rand_pay(10); f0 = frames; sf0 = n_sf;
        send(pa, -1, -1); quiet(); wait_frames(f0 + 1);
        chk("t2_len", rx.size(), 72);
        chk("t2_bytes", diffs(rx, build_exp(pa)), 0);
        chk("t2_residue", crc_reg(rx, 8), 32'hDEBB20E3);

        // back-to-back frames with s_valid held high
        pa = rand_pay($urandom_range(5, 70)); pb = rand_pay($urandom_range(5, 70)); f0 = frames;
        send(pa, -1, -1); send(pb, -1, -1);
        chk("t3_a_bytes", diffs(rx, build_exp(pa)), 0);
        quiet(); wait_frames(f0 + 2);
        chk("t3_gap", last_gap, 12);
        chk("t3_b_bytes", diffs(rx, build_exp(pb)), 0);

        // s_error on byte 5 of 20
        pa = rand_pay(20); f0 = frames; sf0 = n_sf; sa0 = n_sa;
        send(pa, 4, -1);
        pb = rand_pay(30); send(pb, -1, -1);
        chk("t4_abort_bytes", diffs(rx, build_abort(pa, 4)), 0);
        chk("t4_tx_err_cycles", rx_err, 1);
        chk("t4_stat_abort", n_sa - sa0, 1);
        quiet(); wait_frames(f0 + 2);
        chk("t4_next_bytes", diffs(rx, build_exp(pb)), 0);
        chk("t4_next_err", rx_err, 0);
        chk("t4_gap_ge_12", last_gap >= 12, 1);
        chk("t4_stat_frame", n_sf - sf0, 1);

        // underrun after 3 bytes
        pa = rand_pay(10); f0 = frames; sa0 = n_sa;
        send(pa, -1, 3);
        pb = rand_pay(16); send(pb, -1, -1);
        chk("t5_abort_bytes", diffs(rx, build_abort(pa, 3)), 0);
        chk("t5_tx_err_cycles", rx_err, 1);
        chk("t5_stat_abort", n_sa - sa0, 1);
        quiet(); wait_frames(f0 + 2);
        chk("t5_gap_ge_12", last_gap >= 12, 1);
        chk("t5_next_bytes", diffs(rx, build_exp(pb)), 0);

        // minimal config: 3 preamble bytes, no pad, no FCS
        @(negedge clk); v6 = 1'b1; d6 = 8'($urandom); l6 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_pre_en", en6, 1);
            chk("t6_pre_data", data6, 8'h55);
        end
        @(negedge clk);
        chk("t6_sfd", data6, 8'hD5);
        chk("t6_sfd_ready", ready6, 1);
        @(negedge clk);
        chk("t6_byte", data6, d6);
        chk("t6_stat_frame", sf6, 1);
        v6 = 1'b0; l6 = 1'b0;
        @(negedge clk);
        chk("t6_idle_en", en6, 0);
        chk("t6_stat_frame_low", sf6, 0);
        repeat (20) @(negedge clk);
        v6 = 1'b1; d6 = 8'($urandom);
        @(negedge clk);
        chk("t6_restart_en", en6, 1);
        #2 rst_n6 = 1'b0;
        #1;
        chk("t6_async_en", en6, 0);
        chk("t6_async_err", err6, 0);
        chk("t6_async_busy", busy6, 0);
        @(negedge clk); rst_n6 = 1'b1; v6 = 1'b0;

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
